// File: rtl/mem_block_copier.sv
// mem_block_copier: DMA block copy engine on the 6502 memory port, 2 cycles/byte (READ, WRITE).
// Optional build macro MEM_COPIER_FILL_EN adds FillMode/FillData for a 1 cycle/byte constant fill.
module mem_block_copier #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Src,
  input  logic [ADDR_W-1:0] Dst,
  input  logic [LEN_W-1:0]  Len,
`ifdef MEM_COPIER_FILL_EN
  input  logic              FillMode,
  input  logic [DATA_W-1:0] FillData,
`endif
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_count;
  logic              r_done;
  logic              w_accept;
  logic              w_fill_in;
  logic              w_fill;
  logic [DATA_W-1:0] w_fdata;

  assign w_accept = (r_state == S_IDLE) && Start && (Len != '0);

`ifdef MEM_COPIER_FILL_EN
  logic              r_fill;
  logic [DATA_W-1:0] r_fdata;
  assign w_fill_in = FillMode;
  assign w_fill    = r_fill;
  assign w_fdata   = r_fdata;

  // Fill mode and pattern are captured with the rest of the request
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fill  <= 1'b0;
      r_fdata <= '0;
    end else if (w_accept) begin
      r_fill  <= FillMode;
      r_fdata <= FillData;
    end
  end
`else
  assign w_fill_in = 1'b0;
  assign w_fill    = 1'b0;
  assign w_fdata   = '0;
`endif

  // Transfer sequencer: IDLE accepts, READ presents src, WRITE stores and advances
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_src   <= Src;
          r_dst   <= Dst;
          r_count <= Len;
          r_state <= w_fill_in ? S_WRITE : S_READ;
        end else if (Start) begin
          r_done <= 1'b1;
        end
      end else if (r_state == S_READ) begin
        r_state <= S_WRITE;
      end else begin
        r_src   <= r_src + ADDR_W'(1);
        r_dst   <= r_dst + ADDR_W'(1);
        r_count <= r_count - LEN_W'(1);
        if (r_count == LEN_W'(1)) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= w_fill ? S_WRITE : S_READ;
        end
      end
    end
  end

  assign Busy     = r_state != S_IDLE;
  assign Done     = r_done;
  assign MemWE    = r_state == S_WRITE;
  assign MemAddr  = (r_state == S_READ) ? r_src : (r_state == S_WRITE) ? r_dst : '0;
  assign MemWData = MemWE ? (w_fill ? w_fdata : MemRData) : '0;

endmodule
